// File: rtl/video_pkg.sv
// Shared definitions for the video scandoubler.
//   COLOR_W        palettised colour width
//   *_DEF          default geometry (pixels per line, line buffer address width, hsync width)
//   rd_state_e     replay engine state encoding
package video_pkg;

    localparam int unsigned COLOR_W       = 6;
    localparam int unsigned LINE_MAX_DEF  = 448;
    localparam int unsigned ADDR_W_DEF    = 9;
    localparam int unsigned HSYNC_LEN_DEF = 54;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPass0 = 2'd1,
        StPass1 = 2'd2,
        StHold  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/video_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, bank bit is the address MSB.
//   i_clk      clock
//   i_we       write enable
//   i_waddr    write address {bank, pixel}
//   i_wdata    write data
//   i_re       read enable
//   i_raddr    read address {bank, pixel}
//   o_rdata    registered read data (holds when i_re is low)
// No reset on the array or the read register so it maps onto block RAM.
module video_linebuf #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 6
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/video_scandoubler.sv
// 15 kHz -> 31 kHz scandoubler. Captures each input line into one bank of a ping-pong
// buffer while the previous line is replayed twice at twice the pixel rate.
//   clk             28 MHz clock
//   rst             asynchronous active-high reset
//   color_in        palettised colour from the mixer
//   pix_stb         input pixel strobe (every 4th clk)
//   line_start      start of input line strobe
//   vga_color       VGA-rate colour, held between strobes
//   vga_stb         VGA pixel strobe (every 2nd clk during a pass)
//   vga_hsync       VGA hsync, active-high, first HSYNC_LEN pixels of each pass
//   vga_line_start  pulse with the first vga_stb of each pass
module video_scandoubler
    import video_pkg::*;
#(
    parameter int unsigned LINE_MAX  = LINE_MAX_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned HSYNC_LEN = HSYNC_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               pix_stb,
    input  logic               line_start,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_stb,
    output logic               vga_hsync,
    output logic               vga_line_start
);

    localparam logic [ADDR_W:0]   WPTR_MAX  = (ADDR_W+1)'(LINE_MAX);
    localparam logic [ADDR_W-1:0] RPTR_LAST = ADDR_W'(LINE_MAX - 1);
    localparam logic [ADDR_W:0]   HS_END    = (ADDR_W+1)'(HSYNC_LEN);

    // Write side
    logic              r_wbank, r_rbank;
    logic [ADDR_W:0]   r_wptr, r_len;
    logic              w_wbank_nxt, w_rbank_nxt;
    logic [ADDR_W:0]   w_wptr_nxt, w_len_nxt;
    logic              w_we;
    logic [ADDR_W:0]   w_waddr;

    // Read engine
    rd_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_rptr, w_rptr_nxt;
    logic              r_rphase, w_rphase_nxt;
    logic              w_issue, w_in_pass, w_active;
    logic [ADDR_W:0]   w_raddr;
    logic [COLOR_W-1:0] w_rdata;

    // Pipeline stage 1 (aligned with the registered RAM read)
    logic r_vld1, r_first1, r_pad1, r_hs1, r_act1;

    // Output registers
    logic [COLOR_W-1:0] r_vga_color;
    logic               r_vga_stb, r_vga_hs, r_vga_ls;

    always_comb begin
        w_wbank_nxt = r_wbank;
        w_rbank_nxt = r_rbank;
        w_wptr_nxt  = r_wptr;
        w_len_nxt   = r_len;
        w_we        = 1'b0;
        w_waddr     = {r_wbank, r_wptr[ADDR_W-1:0]};
        if (line_start) begin
            w_wbank_nxt = ~r_wbank;
            w_rbank_nxt = r_wbank;
            w_len_nxt   = r_wptr;
            w_wptr_nxt  = '0;
            // A pixel arriving with line_start is the first pixel of the new line.
            if (pix_stb) begin
                w_we       = 1'b1;
                w_waddr    = {~r_wbank, {ADDR_W{1'b0}}};
                w_wptr_nxt = (ADDR_W+1)'(1);
            end
        end else if (pix_stb && (r_wptr != WPTR_MAX)) begin
            w_we       = 1'b1;
            w_wptr_nxt = r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbank <= 1'b0;
            r_rbank <= 1'b1;
            r_wptr  <= '0;
            r_len   <= '0;
        end else begin
            r_wbank <= w_wbank_nxt;
            r_rbank <= w_rbank_nxt;
            r_wptr  <= w_wptr_nxt;
            r_len   <= w_len_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rptr_nxt   = r_rptr;
        w_rphase_nxt = r_rphase;
        w_issue      = 1'b0;
        w_in_pass    = (r_state == StPass0) || (r_state == StPass1);
        if (line_start) begin
            // Restart immediately; a read due this cycle is dropped.
            w_state_nxt  = StPass0;
            w_rptr_nxt   = '0;
            w_rphase_nxt = 1'b0;
        end else if (w_in_pass) begin
            w_rphase_nxt = ~r_rphase;
            if (r_rphase) begin
                w_issue = 1'b1;
                if (r_rptr == RPTR_LAST) begin
                    w_rptr_nxt  = '0;
                    w_state_nxt = (r_state == StPass0) ? StPass1 : StHold;
                end else begin
                    w_rptr_nxt = r_rptr + 1'b1;
                end
            end
        end
    end

    assign w_active = w_in_pass || line_start;
    assign w_raddr  = {r_rbank, r_rptr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_rptr   <= '0;
            r_rphase <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rptr   <= w_rptr_nxt;
            r_rphase <= w_rphase_nxt;
        end
    end

    video_linebuf #(
        .ADDR_W (ADDR_W + 1),
        .DATA_W (COLOR_W)
    ) u_linebuf (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (color_in),
        .i_re    (w_issue),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld1      <= 1'b0;
            r_first1    <= 1'b0;
            r_pad1      <= 1'b0;
            r_hs1       <= 1'b0;
            r_act1      <= 1'b0;
            r_vga_color <= '0;
            r_vga_stb   <= 1'b0;
            r_vga_hs    <= 1'b0;
            r_vga_ls    <= 1'b0;
        end else begin
            r_vld1 <= w_issue;
            r_act1 <= w_active;
            if (w_issue) begin
                r_first1 <= (r_rptr == '0);
                // Pixels beyond the captured length replay as black.
                r_pad1   <= ({1'b0, r_rptr} >= r_len);
                r_hs1    <= ({1'b0, r_rptr} < HS_END);
            end else if (!w_active) begin
                r_hs1 <= 1'b0;
            end

            r_vga_stb <= r_vld1;
            r_vga_ls  <= r_vld1 && r_first1;
            r_vga_hs  <= r_hs1;
            if (r_vld1) begin
                r_vga_color <= r_pad1 ? '0 : w_rdata;
            end else if (!r_act1) begin
                r_vga_color <= '0;
            end
        end
    end

    assign vga_color      = r_vga_color;
    assign vga_stb        = r_vga_stb;
    assign vga_hsync      = r_vga_hs;
    assign vga_line_start = r_vga_ls;

endmodule

// File: tb/tb_video_scandoubler.sv
// Self-checking bench for video_scandoubler. A monitor logs every VGA strobe; the
// expected stream is derived from the captured line: two passes of LMAX pixels,
// pixel r = line[r] or 0 past the line length, hsync for r < HS, first strobe
// 3 clocks after the edge that samples line_start, one strobe every 2 clocks.
module tb_video_scandoubler;

    localparam int LMAX = 448;
    localparam int HS   = 54;

    typedef logic [5:0] pix_q_t[$];
    typedef struct {
        int         cyc;
        logic [5:0] col;
        logic       ls;
        logic       hs;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] color_in = '0;
    logic       pix_stb = 1'b0;
    logic       line_start = 1'b0;
    logic [5:0] vga_color;
    logic       vga_stb, vga_hsync, vga_line_start;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   orphan = 0;
    ev_t  mon_q[$];

    video_scandoubler dut (
        .clk            (clk),
        .rst            (rst),
        .color_in       (color_in),
        .pix_stb        (pix_stb),
        .line_start     (line_start),
        .vga_color      (vga_color),
        .vga_stb        (vga_stb),
        .vga_hsync      (vga_hsync),
        .vga_line_start (vga_line_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (vga_stb) mon_q.push_back('{cyc, vga_color, vga_line_start, vga_hsync});
            if (vga_line_start && !vga_stb) orphan = orphan + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp, input string detail);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d %s", tag, obs, exp, detail);
        end
    endtask

    // mode 0: random, 1: ramp, 2: constant 2A
    task automatic send_line(input int n, input int mode, output pix_q_t model);
        logic [5:0] c;
        model = {};
        for (int i = 0; i < n; i++) begin
            c = (mode == 1) ? 6'(i) : (mode == 2) ? 6'h2A : 6'($urandom);
            color_in = c;
            pix_stb  = 1'b1;
            tick(1);
            pix_stb  = 1'b0;
            tick(3);
            if (i < LMAX) model.push_back(c);
        end
    endtask

    task automatic pulse_ls(input logic with_pix, input logic [5:0] c, output int at);
        line_start = 1'b1;
        pix_stb    = with_pix;
        color_in   = c;
        at         = cyc;
        tick(1);
        line_start = 1'b0;
        pix_stb    = 1'b0;
    endtask

    task automatic check_stream(input int first, input int n, input int base, input pix_q_t line,
                                output int bad, output string msg);
        ev_t        e;
        logic [5:0] ec;
        logic       el, eh;
        int         r;
        bad = 0;
        msg = "";
        for (int k = 0; k < n; k++) begin
            if (first + k >= mon_q.size()) begin
                bad++;
                if (bad == 1) msg = $sformatf("strobe %0d missing", k);
            end else begin
                e  = mon_q[first + k];
                r  = k % LMAX;
                ec = (r < line.size()) ? line[r] : 6'd0;
                el = (r == 0);
                eh = (r < HS);
                if (e.cyc != base + 2 * k || e.col !== ec || e.ls !== el || e.hs !== eh) begin
                    bad++;
                    if (bad == 1)
                        msg = $sformatf("first at k=%0d: cyc %0d/%0d col %h/%h ls %b/%b hs %b/%b",
                                        k, e.cyc, base + 2 * k, e.col, ec, e.ls, el, e.hs, eh);
                end
            end
        end
    endtask

    task automatic check_replay(input string tag, input pix_q_t line, input int at);
        int    bad;
        string msg;
        tick(2 * 2 * LMAX + 20);
        chk({tag, " strobe count"}, mon_q.size(), 2 * LMAX, "");
        check_stream(0, 2 * LMAX, at + 4, line, bad, msg);
        chk({tag, " stream errors"}, bad, 0, msg);
        chk({tag, " quiet after passes"}, int'({vga_stb, vga_hsync, vga_line_start, vga_color}), 0,
            "");
    endtask

    pix_q_t line_a, line_b, line_c, line_e, line_f, empty_q, tmp_q;
    int     at_a, at_b, at_c, at_d, at_e, at_f;
    int     quiet, ls_n, ls_c0, ls_c1, hs_n, old_n, bad, target, n;
    string  msg;

    initial begin
        empty_q = {};
        tick(3);
        chk("reset vga_stb", int'(vga_stb), 0, "");
        chk("reset vga_color", int'(vga_color), 0, "");
        chk("reset vga_hsync", int'(vga_hsync), 0, "");
        chk("reset vga_line_start", int'(vga_line_start), 0, "");
        rst = 1'b0;

        // Idle with no line_start
        quiet = 0;
        repeat (4000) begin
            @(negedge clk);
            if (vga_stb || vga_hsync || vga_line_start || vga_color != 0) quiet++;
        end
        @(posedge clk);
        #1;
        chk("idle activity", quiet, 0, "");

        // Line A: ramp
        send_line(LMAX, 1, line_a);
        mon_q.delete();
        pulse_ls(1'b0, 6'd0, at_a);
        check_replay("ramp", line_a, at_a);
        ls_n = 0;
        ls_c0 = 0;
        ls_c1 = 0;
        foreach (mon_q[i]) begin
            if (mon_q[i].ls) begin
                if (ls_n == 0) ls_c0 = mon_q[i].cyc;
                else ls_c1 = mon_q[i].cyc;
                ls_n++;
            end
        end
        chk("ramp line_start count", ls_n, 2, "");
        chk("ramp line_start spacing", ls_c1 - ls_c0, 2 * LMAX, "");
        chk("ramp first pixel latency", ls_c0 - at_a, 4, "");

        // Short line: 100 x 2A
        send_line(100, 2, tmp_q);
        mon_q.delete();
        pulse_ls(1'b0, 6'd0, at_b);
        check_replay("short", tmp_q, at_b);
        hs_n = 0;
        foreach (mon_q[i]) if (mon_q[i].hs) hs_n++;
        chk("short hsync strobes", hs_n, 2 * HS, "");

        // Overlong line: 500 pixels, the last 52 are dropped
        send_line(500, 0, tmp_q);
        mon_q.delete();
        pulse_ls(1'b0, 6'd0, at_b);
        check_replay("overlong", tmp_q, at_b);
        tick(1000);
        chk("hold no strobes", mon_q.size(), 2 * LMAX, "");

        // Random length line
        n = $urandom_range(1, LMAX - 1);
        send_line(n, 0, tmp_q);
        mon_q.delete();
        pulse_ls(1'b0, 6'd0, at_b);
        check_replay("random", tmp_q, at_b);

        // Abandon PASS1 at rptr 200 while the next line has been captured
        send_line($urandom_range(200, LMAX), 0, line_b);
        mon_q.delete();
        pulse_ls(1'b0, 6'd0, at_b);
        send_line(250, 0, line_c);
        target = at_b + 2 + 2 * (LMAX + 200);
        tick(target - cyc);
        pulse_ls(1'b0, 6'd0, at_c);
        tick(2 * 2 * LMAX + 20);
        old_n = 0;
        foreach (mon_q[i]) if (mon_q[i].cyc < at_c + 4) old_n++;
        chk("abandon old strobes in range", int'(old_n == LMAX + 200 || old_n == LMAX + 201), 1,
            $sformatf("old strobes %0d", old_n));
        check_stream(0, old_n, at_b + 4, line_b, bad, msg);
        chk("abandon old stream", bad, 0, msg);
        check_stream(old_n, 2 * LMAX, at_c + 4, line_c, bad, msg);
        chk("abandon new stream", bad, 0, msg);
        chk("abandon total strobes", mon_q.size(), old_n + 2 * LMAX, "");

        // pix_stb coincident with line_start: completes an empty line, starts the next with 15
        mon_q.delete();
        pulse_ls(1'b1, 6'h15, at_d);
        send_line(19, 0, tmp_q);
        check_replay("empty line", empty_q, at_d);
        line_e = {6'h15};
        foreach (tmp_q[i]) line_e.push_back(tmp_q[i]);
        mon_q.delete();
        pulse_ls(1'b0, 6'd0, at_e);
        tick(300);
        rst = 1'b1;
        tick(1);
        chk("midpass reset outputs", int'({vga_stb, vga_hsync, vga_line_start, vga_color}), 0, "");
        chk("coincident first pixel", (mon_q.size() > 0) ? int'(mon_q[0].col) : -1, 'h15, "");
        chk("pre-reset strobes", mon_q.size(), 149, "");
        check_stream(0, mon_q.size(), at_e + 4, line_e, bad, msg);
        chk("pre-reset stream", bad, 0, msg);
        rst = 1'b0;
        mon_q.delete();
        tick(1000);
        chk("post-reset idle strobes", mon_q.size(), 0, "");

        // Fresh line after reset
        send_line(10, 0, line_f);
        mon_q.delete();
        pulse_ls(1'b0, 6'd0, at_f);
        check_replay("after reset", line_f, at_f);

        chk("orphan line_start pulses", orphan, 0, "");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_scandoubler.md
Name: video_scandoubler

Overview:
- Converts the 15 kHz TV-rate palettised colour stream into a 31 kHz VGA-rate stream.
- Sits directly downstream of the palette/frame mixer: consumes its 6-bit colour at the 7 MHz pixel rate.
- Stores each input line in a ping-pong line buffer, then replays the previous line twice at 14 MHz, generating VGA hsync.
- Single 28 MHz clock domain; rate control is by strobes only.

Parameters:
LINE_MAX, 448, input pixels per line; also the VGA pixels per replay pass.
ADDR_W, 9, line buffer address width (depth 2^ADDR_W per bank, must be >= LINE_MAX).
HSYNC_LEN, 54, VGA hsync width in 14 MHz pixels.

Ports:
clk  input  1  28 MHz system clock
rst  input  1  asynchronous, active-high reset
color_in  input  6  palettised colour from the palette/frame mixer (already blanked)
pix_stb  input  1  one-clk strobe per input pixel (every 4th clk)
line_start  input  1  one-clk strobe marking the start of an input line
vga_color  output  6  VGA-rate colour
vga_stb  output  1  one-clk strobe, every 2nd clk, qualifying vga_color
vga_hsync  output  1  VGA horizontal sync, active-high
vga_line_start  output  1  one-clk pulse with the first vga_stb of each replay pass

Behaviour:
- Reset: all outputs 0, wbank=0, rbank=1, wptr=0, len_reg=0, read engine IDLE. Buffer RAM contents are not reset.
- Write side:
  - On pix_stb: buf[wbank][wptr] <= color_in, then wptr increments.
  - At wptr = LINE_MAX, further writes are dropped (wptr saturates at LINE_MAX, no wrap).
- line_start:
  - wbank toggles; rbank <= old wbank; len_reg <= wptr (pixels captured in the completed line); wptr <= 0.
  - Simultaneous pix_stb: the pixel is written to address 0 of the new wbank and wptr <= 1.
- Read engine states:
  - IDLE: outputs 0, no vga_stb.
  - PASS0, PASS1: replay passes.
  - HOLD: outputs 0, no vga_stb.
- Transitions:
  - line_start from any state -> PASS0, rptr <= 0, rphase <= 0. A pass in progress is abandoned immediately.
  - In a pass: rphase toggles every clk; each rphase=1 clk issues a read at rptr and rptr increments.
  - rptr = LINE_MAX-1 read issued in PASS0 -> PASS1, rptr <= 0.
  - Same condition in PASS1 -> HOLD.
  - HOLD persists until line_start.
- Output pipeline:
  - RAM read is registered. vga_color and vga_stb appear exactly 2 clk after the read issue cycle and stay mutually aligned.
  - vga_color holds its value between strobes.
  - Reads with rptr >= len_reg output 6'd0 (short input line padding).
- vga_line_start: asserted with the vga_stb carrying rptr=0 of each pass.
- vga_hsync: high for the vga_stb slots rptr 0..HSYNC_LEN-1 of each pass, aligned to the output pipeline. It is low in IDLE and HOLD.
- Latency: first VGA pixel of a pass is presented 3 clk after line_start (1 clk state entry + 2 clk pipeline).
- Bank aliasing:
  - Read always targets rbank and write always targets wbank. They are distinct after any line_start, so no read/write collision.
  - Before the first line_start (IDLE) no reads occur.
- Reset asserted mid-pass: immediate return to reset values, with no partial strobe afterwards.

Decomposition:
- Package video_pkg:
  - COLOR_W=6, LINE_MAX, ADDR_W, HSYNC_LEN defaults.
  - Read-state encoding constants (IDLE, PASS0, PASS1, HOLD).
- Sub-module video_linebuf:
  - 2 x 2^ADDR_W x COLOR_W simple dual-port RAM with bank bit as the address MSB.
  - One write port, one registered read port, no reset.
  - Inferred as block RAM.

Test Plan:
- Reset then idle with no line_start -> vga_stb, vga_color, vga_hsync and vga_line_start stay 0 for 4000 clk.
- Line A is pixels 0..447 with color_in=addr[5:0], then line_start -> vga_line_start twice, 896 clk apart. Each pass outputs 448 strobes with colours 0,1,..,63,0,... in order, and the first colour appears 3 clk after line_start.
- Short line of 100 pixels (all 6'h2A), then line_start -> each pass outputs 100 x 2A then 348 x 00, with vga_hsync high for exactly the first 54 strobes of each pass.
- Overlong line of 500 pix_stb, then line_start -> len_reg=448, pixels 448..499 dropped. After both passes the engine holds (no vga_stb) until the next line_start.
- line_start mid-PASS1 (at rptr=200) -> the pass is abandoned and a new PASS0 starts from rptr 0. Output shows the newly completed line, with no glitch strobe.
- pix_stb coincident with line_start carrying 6'h15 -> the next line's first replayed pixel is 15. Then assert rst mid-pass -> all outputs 0 on the next edge and the engine is IDLE.
